// File: rtl/uart_tx_fifo_if.sv
// Transmit-FIFO bus: write side from the register block, read side and
// status toward the UART transmitter and status register.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_n;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic                  afull;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, rd_n, clr_ovf,
        input  rd_data, empty, full, afull, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_n, clr_ovf,
        output rd_data, empty, full, afull, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO feeding the UART transmitter. Bytes are pushed by
// the register interface and popped by an active-low one-cycle read strobe;
// read data is registered and holds until the next accepted read.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input logic           i_clk,
    input logic           i_reset_n,
    uart_tx_fifo_if.slave io_bus
);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_overflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_afull;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_rej;

    // Status flags come only from the count register; accept decisions use them.
    // A write while full still succeeds if a read frees the slot in the same cycle.
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == FULL_CNT);
        w_afull  = (r_count >= AFULL_CNT);
        w_rd_acc = ~io_bus.rd_n & ~w_empty;
        w_wr_acc = io_bus.wr_en & (~w_full | w_rd_acc);
        w_wr_rej = io_bus.wr_en & ~w_wr_acc;
    end

    // Occupancy changes only when exactly one side is accepted.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= io_bus.wr_data;
        end
    end

    // Pointers, count, read data and sticky overflow (set beats clear).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_rej) begin
                r_overflow <= 1'b1;
            end else if (io_bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign io_bus.rd_data  = r_rd_data;
    assign io_bus.empty    = w_empty;
    assign io_bus.full     = w_full;
    assign io_bus.afull    = w_afull;
    assign io_bus.count    = r_count;
    assign io_bus.overflow = r_overflow;
endmodule
